calc1_req_sequencer: RTL and testbench
======================================

Name: calc1_req_sequencer

Overview:
Upstream stimulus stage for the calc1 adder port. It accepts one operation request (command plus two operands) over a valid/ready handshake and serialises it onto the calc1 port protocol: command with operand 1, then operand 2, then idle. It waits for the port response, with a timeout, and returns the result code and data over a second valid/ready handshake. Only one operation is in flight at a time.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles allowed without a response before a timeout is reported; legal range 2..255.

Ports:
c_clk  input  1  sole clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_cmd  input  [0:3]  calc1 command: 1 add, 2 sub, 5 shl, 6 shr; other nonzero values are forwarded unchanged.
req_op1  input  [0:31]  operand 1.
req_op2  input  [0:31]  operand 2.
cmd_in  output  [0:3]  drives calc1 port command.
data_in  output  [0:31]  drives calc1 port data.
resp_out  input  [0:1]  calc1 port response: 0 none, 1 ok, 2 overflow/underflow, 3 invalid.
out_data  input  [0:31]  calc1 port result, valid when resp_out != 0.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes result.
rsp_code  output  [0:1]  captured resp_out, or 3 for a local reject.
rsp_data  output  [0:31]  captured out_data; 0 on timeout or reject.
rsp_timeout  output  1  result is a timeout.
busy  output  1  state != IDLE.

Behaviour:
- All outputs are registered. Reset (synchronous, any state, including mid-operation) forces: state IDLE, req_ready 1, cmd_in 0, data_in 0, rsp_valid 0, rsp_code 0, rsp_data 0, rsp_timeout 0, busy 0, timeout counter 0. An in-flight operation is abandoned. Its late response counts as stray.
- States: IDLE, SEND1, SEND2, WAIT, HOLD.
- IDLE: req_ready = 1. Accept occurs at edge N when req_valid && req_ready.
  - Accept with req_cmd != 0: latch cmd/op1/op2 and go to SEND1.
  - Accept with req_cmd == 0: go to HOLD with rsp_code 3, rsp_data 0, rsp_timeout 0. No port traffic.
- SEND1 (cycle N+1): cmd_in = latched cmd, data_in = op1. Next state SEND2.
- SEND2 (cycle N+2): cmd_in = 0, data_in = op2. resp_out is sampled.
  - If resp_out != 0, capture it and go to HOLD.
  - Otherwise go to WAIT.
- WAIT (cycles N+3 onward): cmd_in = 0, data_in = 0. The counter starts at 0 on entry.
  - resp_out != 0: capture resp_out and out_data, go to HOLD.
  - Otherwise, with counter == TIMEOUT_CYCLES-1: go to HOLD with rsp_timeout 1, rsp_code 0, rsp_data 0.
  - Otherwise: increment the counter.
- HOLD: rsp_valid = 1. rsp_code, rsp_data and rsp_timeout are stable while rsp_ready = 0. req_ready = 0.
  - On rsp_valid && rsp_ready: clear rsp_valid and rsp_timeout, go to IDLE. req_ready = 1 from the next cycle.
  - No same-cycle request accept.
- Latency: a response seen at cycle M sets rsp_valid at M+1. Minimum accept-to-rsp_valid is 3 cycles (response in SEND2).
- Stray response (resp_out != 0 in IDLE, SEND1 or HOLD) is ignored and never overwrites held results.
- Only one response per operation is captured. A second nonzero resp_out in HOLD is stray.

Optional Feature:
Macro CALC1_SEQ_STRAY_CNT_EN.
- Defined: adds output stray_cnt [0:7], a saturating count of stray responses. Reset sets it to 0. It holds at 255.
- Undefined: no port and no logic. Stray responses are silently ignored.

Test Plan:
- Add: req cmd 1, op1 5, op2 7. Model responds resp 1, data 12 at N+5. Required: cmd_in 1 / data_in 5 at N+1; cmd_in 0 / data_in 7 at N+2; rsp_valid at N+6 with code 1, data 12.
- Overflow: cmd 1, op1 32'hFFFFFFFF, op2 1. Model responds resp 2. Required: rsp_code 2, rsp_timeout 0.
- Timeout: TIMEOUT_CYCLES=8, model never responds. Required: rsp_valid at N+11, rsp_timeout 1, rsp_code 0, rsp_data 0.
- Back-pressure: rsp_ready low 5 cycles after rsp_valid, with a stray resp 3 injected during HOLD. Required: outputs unchanged, req_ready 0. With the macro, stray_cnt = 1. Handshake then returns to IDLE.
- Local reject: req cmd 0. Required: cmd_in stays 0 throughout; rsp_valid at N+1, code 3.
- Reset mid-WAIT: assert reset for 1 cycle at N+4. Required: all outputs at reset values next cycle, req_ready 1. A later model response is ignored (stray_cnt 1 with the macro).

Source files
------------

// File: rtl/calc1_req_sequencer_if.sv
// Handshake and calc1 port bundle for calc1_req_sequencer.
// master = the sequencer; slave = request source, result consumer and calc1 port.
interface calc1_req_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [0:3]  req_cmd;
  logic [0:31] req_op1;
  logic [0:31] req_op2;
  logic [0:3]  cmd_in;
  logic [0:31] data_in;
  logic [0:1]  resp_out;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    input  req_valid, req_cmd, req_op1, req_op2, resp_out, out_data, rsp_ready,
    output req_ready, cmd_in, data_in, rsp_valid, rsp_code, rsp_data, rsp_timeout, busy
  );

  modport slave (
    output req_valid, req_cmd, req_op1, req_op2, resp_out, out_data, rsp_ready,
    input  req_ready, cmd_in, data_in, rsp_valid, rsp_code, rsp_data, rsp_timeout, busy
  );
endinterface

// File: rtl/calc1_req_sequencer.sv
// Serialises one calc1 request onto the port, waits (with timeout) and returns the result.
// Optional CALC1_SEQ_STRAY_CNT_EN adds a saturating stray-response counter output.
module calc1_req_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic c_clk,
  input  logic reset,
  calc1_req_sequencer_if.master bus
`ifdef CALC1_SEQ_STRAY_CNT_EN
  ,
  output logic [0:7] stray_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT, S_HOLD} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [0:31] op2_q, op2_d;
  logic [0:3]  cmd_in_q, cmd_in_d;
  logic [0:31] data_in_q, data_in_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [0:1]  rsp_code_q, rsp_code_d;
  logic [0:31] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        busy_q, busy_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d       = state_q;
    cnt_d         = cnt_q;
    op2_d         = op2_q;
    cmd_in_d      = cmd_in_q;
    data_in_d     = data_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_code_d    = rsp_code_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          if (bus.req_cmd != 4'd0) begin
            state_d   = S_SEND1;
            cmd_in_d  = bus.req_cmd;
            data_in_d = bus.req_op1;
            op2_d     = bus.req_op2;
          end else begin
            // Local reject: no port traffic, result code 3.
            state_d       = S_HOLD;
            rsp_valid_d   = 1'b1;
            rsp_code_d    = 2'd3;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b0;
          end
        end
      end
      S_SEND1: begin
        state_d   = S_SEND2;
        cmd_in_d  = '0;
        data_in_d = op2_q;
      end
      S_SEND2: begin
        data_in_d = '0;
        if (bus.resp_out != 2'd0) begin
          state_d       = S_HOLD;
          rsp_valid_d   = 1'b1;
          rsp_code_d    = bus.resp_out;
          rsp_data_d    = bus.out_data;
          rsp_timeout_d = 1'b0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (bus.resp_out != 2'd0) begin
          state_d       = S_HOLD;
          rsp_valid_d   = 1'b1;
          rsp_code_d    = bus.resp_out;
          rsp_data_d    = bus.out_data;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_HOLD;
          rsp_valid_d   = 1'b1;
          rsp_code_d    = 2'd0;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d       = S_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge c_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op2_q         <= '0;
      cmd_in_q      <= '0;
      data_in_q     <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op2_q         <= op2_d;
      cmd_in_q      <= cmd_in_d;
      data_in_q     <= data_in_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_code_q    <= rsp_code_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.cmd_in      = cmd_in_q;
  assign bus.data_in     = data_in_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_code    = rsp_code_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = busy_q;

`ifdef CALC1_SEQ_STRAY_CNT_EN
  logic       stray;
  logic [0:7] stray_cnt_q, stray_cnt_d;

  // A response outside SEND2/WAIT belongs to no live operation.
  always_comb begin
    stray       = (bus.resp_out != 2'd0) &&
                  (state_q == S_IDLE || state_q == S_SEND1 || state_q == S_HOLD);
    stray_cnt_d = stray_cnt_q;
    if (stray && stray_cnt_q != 8'hFF) stray_cnt_d = stray_cnt_q + 8'd1;
  end

  always_ff @(posedge c_clk) begin
    if (reset) stray_cnt_q <= '0;
    else       stray_cnt_q <= stray_cnt_d;
  end

  assign stray_cnt = stray_cnt_q;
`endif

endmodule

// File: tb/tb_calc1_req_sequencer.sv
// Directed self-checking bench for calc1_req_sequencer (TIMEOUT_CYCLES = 8).
// Cycle N+k is the cycle following the k-th rising edge after the accept edge N.
module tb_calc1_req_sequencer;
  logic c_clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  calc1_req_sequencer_if bus ();
`ifdef CALC1_SEQ_STRAY_CNT_EN
  logic [0:7] stray_cnt;
`endif

  calc1_req_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef CALC1_SEQ_STRAY_CNT_EN
    ,
    .stray_cnt (stray_cnt)
`endif
  );

  always #5 c_clk = ~c_clk;

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic cyc();
    @(posedge c_clk);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle N+1.
  task automatic send_req(input logic [0:3] cmd, input logic [0:31] op1, input logic [0:31] op2);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_op1   = op1;
    bus.req_op2   = op2;
    cyc();
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
  endtask

  task automatic test_handshake(input string name);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_valid got %0b exp 0", name, bus.rsp_valid); end
    checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL %s_tmo got %0b exp 0", name, bus.rsp_timeout); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %0b exp 1", name, bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0b exp 0", name, bus.busy); end
  endtask

  task automatic check_reset_values(input string name);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %0b exp 1", name, bus.req_ready); end
    checks++; if (bus.cmd_in !== 4'd0) begin errors++; $display("FAIL %s_cmd got %0d exp 0", name, bus.cmd_in); end
    checks++; if (bus.data_in !== 32'd0) begin errors++; $display("FAIL %s_data got %0d exp 0", name, bus.data_in); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_valid got %0b exp 0", name, bus.rsp_valid); end
    checks++; if (bus.rsp_code !== 2'd0) begin errors++; $display("FAIL %s_code got %0d exp 0", name, bus.rsp_code); end
    checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL %s_rdata got %0d exp 0", name, bus.rsp_data); end
    checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL %s_tmo got %0b exp 0", name, bus.rsp_timeout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0b exp 0", name, bus.busy); end
`ifdef CALC1_SEQ_STRAY_CNT_EN
    checks++; if (stray_cnt !== 8'd0) begin errors++; $display("FAIL %s_stray got %0d exp 0", name, stray_cnt); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_add();
    send_req(4'd1, 32'd5, 32'd7);
    checks++; if (bus.cmd_in !== 4'd1) begin errors++; $display("FAIL add_n1_cmd got %0d exp 1", bus.cmd_in); end
    checks++; if (bus.data_in !== 32'd5) begin errors++; $display("FAIL add_n1_data got %0d exp 5", bus.data_in); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_n1_busy got %0b exp 1", bus.busy); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL add_n1_ready got %0b exp 0", bus.req_ready); end
    cyc();
    checks++; if (bus.cmd_in !== 4'd0) begin errors++; $display("FAIL add_n2_cmd got %0d exp 0", bus.cmd_in); end
    checks++; if (bus.data_in !== 32'd7) begin errors++; $display("FAIL add_n2_data got %0d exp 7", bus.data_in); end
    cyc();
    checks++; if (bus.data_in !== 32'd0) begin errors++; $display("FAIL add_n3_data got %0d exp 0", bus.data_in); end
    cyc();
    cyc();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_n5_valid got %0b exp 0", bus.rsp_valid); end
    bus.resp_out = 2'd1;
    bus.out_data = 32'd12;
    cyc();
    bus.resp_out = 2'd0;
    bus.out_data = 32'd0;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_n6_valid got %0b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_code !== 2'd1) begin errors++; $display("FAIL add_code got %0d exp 1", bus.rsp_code); end
    checks++; if (bus.rsp_data !== 32'd12) begin errors++; $display("FAIL add_data got %0d exp 12", bus.rsp_data); end
    checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL add_tmo got %0b exp 0", bus.rsp_timeout); end
    test_handshake("add_hs");
  endtask

  task automatic test_overflow();
    send_req(4'd1, 32'hFFFF_FFFF, 32'd1);
    cyc();
    cyc();
    bus.resp_out = 2'd2;
    cyc();
    bus.resp_out = 2'd0;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_code !== 2'd2) begin errors++; $display("FAIL ovf_code got %0d exp 2", bus.rsp_code); end
    checks++; if (bus.rsp_timeout !== 1'b0) begin errors++; $display("FAIL ovf_tmo got %0b exp 0", bus.rsp_timeout); end
    test_handshake("ovf_hs");
  endtask

  // Response in SEND2 (minimum latency), then a held result under back-pressure with a stray.
  task automatic test_back_pressure();
    send_req(4'd2, 32'd10, 32'd3);
    cyc();
    bus.resp_out = 2'd1;
    bus.out_data = 32'd7;
    cyc();
    bus.resp_out = 2'd0;
    bus.out_data = 32'd0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid got %0b exp 1", i, bus.rsp_valid); end
      checks++; if (bus.rsp_code !== 2'd1) begin errors++; $display("FAIL bp%0d_code got %0d exp 1", i, bus.rsp_code); end
      checks++; if (bus.rsp_data !== 32'd7) begin errors++; $display("FAIL bp%0d_data got %0d exp 7", i, bus.rsp_data); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_ready got %0b exp 0", i, bus.req_ready); end
      bus.resp_out = (i == 1) ? 2'd3 : 2'd0;
      bus.out_data = (i == 1) ? 32'd99 : 32'd0;
      bus.req_valid = (i == 3);
      bus.req_cmd   = (i == 3) ? 4'd1 : 4'd0;
      cyc();
    end
    bus.resp_out  = 2'd0;
    bus.out_data  = 32'd0;
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    checks++; if (bus.rsp_data !== 32'd7) begin errors++; $display("FAIL bp_end_data got %0d exp 7", bus.rsp_data); end
    checks++; if (bus.cmd_in !== 4'd0) begin errors++; $display("FAIL bp_end_cmd got %0d exp 0", bus.cmd_in); end
`ifdef CALC1_SEQ_STRAY_CNT_EN
    checks++; if (stray_cnt !== 8'd1) begin errors++; $display("FAIL bp_stray got %0d exp 1", stray_cnt); end
`endif
    test_handshake("bp_hs");
  endtask

  task automatic test_reject();
    send_req(4'd0, 32'd1, 32'd2);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rej_valid got %0b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_code !== 2'd3) begin errors++; $display("FAIL rej_code got %0d exp 3", bus.rsp_code); end
    checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL rej_data got %0d exp 0", bus.rsp_data); end
    checks++; if (bus.cmd_in !== 4'd0) begin errors++; $display("FAIL rej_cmd got %0d exp 0", bus.cmd_in); end
    cyc();
    checks++; if (bus.cmd_in !== 4'd0) begin errors++; $display("FAIL rej_cmd2 got %0d exp 0", bus.cmd_in); end
    test_handshake("rej_hs");
  endtask

  task automatic test_timeout();
    send_req(4'd2, 32'd4, 32'd9);
    for (int i = 0; i < 9; i++) cyc();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL tmo_n10_valid got %0b exp 0", bus.rsp_valid); end
    cyc();
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL tmo_n11_valid got %0b exp 1", bus.rsp_valid); end
    checks++; if (bus.rsp_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag got %0b exp 1", bus.rsp_timeout); end
    checks++; if (bus.rsp_code !== 2'd0) begin errors++; $display("FAIL tmo_code got %0d exp 0", bus.rsp_code); end
    checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL tmo_data got %0d exp 0", bus.rsp_data); end
    test_handshake("tmo_hs");
  endtask

  task automatic test_reset_mid_wait();
    send_req(4'd1, 32'd3, 32'd4);
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_values("rstw");
    bus.resp_out = 2'd1;
    bus.out_data = 32'd55;
    cyc();
    bus.resp_out = 2'd0;
    bus.out_data = 32'd0;
    cyc();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_late_valid got %0b exp 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'd0) begin errors++; $display("FAIL rstw_late_data got %0d exp 0", bus.rsp_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstw_late_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstw_late_ready got %0b exp 1", bus.req_ready); end
`ifdef CALC1_SEQ_STRAY_CNT_EN
    checks++; if (stray_cnt !== 8'd1) begin errors++; $display("FAIL rstw_stray got %0d exp 1", stray_cnt); end
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.resp_out  = '0;
    bus.out_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_back_pressure();
    test_reject();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
